// File: rtl/spi_3w_master.sv
// Bit-level 3-wire SPI master (mode 3) for the ADXL345: one bit slot per iSPI_CLK cycle, bus turnaround for read data.
// Optional macro SPI_CSN_GAP_EN adds a minimum CSN-high gap of CSN_GAP cycles between frames.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | CSN high, SDIO released, waiting for GO (and gap expiry)
// ST_SHIFT | CSN low, SCLK running, one frame bit per cycle
// ST_DONE  | frame complete, END held until GO is seen low
module spi_3w_master #(
  parameter int FRAME_W = 16,
  parameter int RD_W    = 8,
  parameter int CSN_GAP = 4
) (
  input  logic               iSPI_CLK,
  input  logic               iRSTN,
  input  logic               iSPI_CLK_OUT,
  input  logic [FRAME_W-1:0] iP2S_DATA,
  input  logic               iSPI_GO,
  output logic               oSPI_END,
  output logic [RD_W-1:0]    oS2P_DATA,
  inout  wire                SPI_SDIO,
  output logic               oSPI_CSN,
  output logic               oSPI_CLK
);

  localparam int CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W:0] RD_SLOTS = (CNT_W+1)'(RD_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [FRAME_W-1:0]  tx_sr;
  logic [RD_W-1:0]     rx_sr;
  logic [RD_W-1:0]     s2p_q;
  logic                is_read;
  logic                sclk_en;
  logic                csn_q;
  logic                end_q;
  logic                sdio_oe;
  logic                sdio_out;
  logic                sdio_in;
  logic                start_ok;
  logic                last_slot;
  logic                rx_slot;
  logic                release_slot;

  assign sdio_in      = SPI_SDIO;
  assign last_slot    = (bit_cnt == '0);
  assign rx_slot      = ({1'b0, bit_cnt} < RD_SLOTS);
  assign release_slot = ({1'b0, bit_cnt} <= RD_SLOTS);

`ifdef SPI_CSN_GAP_EN
  // Loaded with CSN_GAP-1 at the last edge: IDLE is entered no earlier than
  // one cycle later, so the start edge lands exactly CSN_GAP cycles after CSN rose.
  localparam int GAP_W = (CSN_GAP > 1) ? $clog2(CSN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (CSN_GAP > 1) ? GAP_W'(CSN_GAP - 1) : '0;

  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      gap_cnt <= '0;
    end else if (state == ST_SHIFT && last_slot) begin
      gap_cnt <= GAP_LOAD;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  assign start_ok = (gap_cnt == '0);
`else
  assign start_ok = 1'b1;
`endif

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state    <= ST_IDLE;
      bit_cnt  <= CNT_W'(FRAME_W - 1);
      tx_sr    <= '0;
      rx_sr    <= '0;
      s2p_q    <= '0;
      is_read  <= 1'b0;
      sclk_en  <= 1'b0;
      csn_q    <= 1'b1;
      end_q    <= 1'b0;
      sdio_oe  <= 1'b0;
      sdio_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iSPI_GO && start_ok) begin
            tx_sr    <= {iP2S_DATA[FRAME_W-2:0], 1'b0};
            is_read  <= iP2S_DATA[FRAME_W-1];
            sdio_out <= iP2S_DATA[FRAME_W-1];
            sdio_oe  <= 1'b1;
            csn_q    <= 1'b0;
            sclk_en  <= 1'b1;
            bit_cnt  <= CNT_W'(FRAME_W - 1);
            state    <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // bit_cnt counts slots still to finish; the edge ending a data slot samples it.
          if (is_read && rx_slot) begin
            rx_sr <= {rx_sr[RD_W-2:0], sdio_in};
          end
          if (last_slot) begin
            sclk_en <= 1'b0;
            csn_q   <= 1'b1;
            sdio_oe <= 1'b0;
            end_q   <= 1'b1;
            bit_cnt <= CNT_W'(FRAME_W - 1);
            state   <= ST_DONE;
            if (is_read) begin
              s2p_q <= {rx_sr[RD_W-2:0], sdio_in};
            end
          end else begin
            sdio_out <= tx_sr[FRAME_W-1];
            tx_sr    <= {tx_sr[FRAME_W-2:0], 1'b0};
            bit_cnt  <= bit_cnt - 1'b1;
            if (is_read && release_slot) begin
              sdio_oe <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          if (!iSPI_GO) begin
            end_q <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // sclk_en only moves on iSPI_CLK rises, where iSPI_CLK_OUT is high, so SCLK never glitches.
  assign oSPI_CLK  = ~sclk_en | iSPI_CLK_OUT;
  assign oSPI_CSN  = csn_q;
  assign oSPI_END  = end_q;
  assign oS2P_DATA = s2p_q;
  assign SPI_SDIO  = sdio_oe ? sdio_out : 1'bz;

endmodule

// File: tb/tb_spi_3w_master.sv
// Directed bench for spi_3w_master: bus monitor, ADXL345-like slave for read data, scoreboard of expected frames.
module tb_spi_3w_master;

  logic        iSPI_CLK = 1'b0;
  logic        iSPI_CLK_OUT = 1'b0;
  logic        iRSTN = 1'b0;
  logic        iSPI_GO = 1'b0;
  logic [15:0] iP2S_DATA = 16'h0000;
  logic        oSPI_END;
  logic [7:0]  oS2P_DATA;
  logic        oSPI_CSN;
  logic        oSPI_CLK;
  wire         SPI_SDIO;

`ifdef SPI_CSN_GAP_EN
  localparam int GAP_EXP = 4;
`else
  localparam int GAP_EXP = 2;
`endif

  typedef struct {
    logic [15:0] bus;
    logic [7:0]  s2p;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  m_s2p = 8'h00;

  logic        slv_oe = 1'b0;
  logic        slv_bit = 1'b0;
  logic        slv_rd = 1'b0;
  logic [7:0]  slv_byte = 8'h00;
  logic [15:0] cap = 16'h0000;
  int          rise_cnt = 0;
  int          csn_high = 0;
  time         t_csn_rise = 0;
  logic        csn_prev = 1'b1;
  logic        clk_prev = 1'b1;

  pullup (SPI_SDIO);
  assign SPI_SDIO = slv_oe ? slv_bit : 1'bz;

  spi_3w_master dut (
    .iSPI_CLK     (iSPI_CLK),
    .iRSTN        (iRSTN),
    .iSPI_CLK_OUT (iSPI_CLK_OUT),
    .iP2S_DATA    (iP2S_DATA),
    .iSPI_GO      (iSPI_GO),
    .oSPI_END     (oSPI_END),
    .oS2P_DATA    (oS2P_DATA),
    .SPI_SDIO     (SPI_SDIO),
    .oSPI_CSN     (oSPI_CSN),
    .oSPI_CLK     (oSPI_CLK)
  );

  // iSPI_CLK_OUT leads iSPI_CLK by a quarter period (period 20)
  initial begin
    forever begin
      iSPI_CLK_OUT = 1'b1; #5;
      iSPI_CLK     = 1'b1; #5;
      iSPI_CLK_OUT = 1'b0; #5;
      iSPI_CLK     = 1'b0; #5;
    end
  end

  // Bus monitor and slave: capture SDIO at SCLK rises, drive read data on SCLK falls of the data slots
  always @(oSPI_CLK or oSPI_CSN) begin
    if (oSPI_CSN !== csn_prev) begin
      if (oSPI_CSN === 1'b1) begin
        t_csn_rise = $time;
        slv_oe = 1'b0;
      end else if (oSPI_CSN === 1'b0) begin
        cap = 16'h0000;
        rise_cnt = 0;
        csn_high = int'(($time - t_csn_rise) / 20);
      end
    end else if (oSPI_CSN === 1'b0 && oSPI_CLK !== clk_prev) begin
      if (oSPI_CLK === 1'b1) begin
        cap = {cap[14:0], SPI_SDIO};
        rise_cnt++;
      end else if (oSPI_CLK === 1'b0 && slv_rd && rise_cnt >= 8 && rise_cnt < 16) begin
        slv_oe = 1'b1;
        slv_bit = slv_byte[15 - rise_cnt];
      end
    end
    csn_prev = oSPI_CSN;
    clk_prev = oSPI_CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_frame(input logic [15:0] word, input logic [7:0] sbyte,
                          input int drop_at, input int hold, input int exp_gap);
    exp_t e;
    int   w;
    int   n;
    e.bus = word[15] ? {word[15:8], sbyte} : word;
    if (word[15]) m_s2p = sbyte;
    e.s2p = m_s2p;
    sb.push_back(e);
    slv_rd = word[15];
    slv_byte = sbyte;

    @(negedge iSPI_CLK);
    iP2S_DATA = word;
    iSPI_GO = 1'b1;
    w = 0;
    do begin
      @(posedge iSPI_CLK); #1;
      w++;
    end while (oSPI_CSN !== 1'b0 && w < 20);
    chk("csn_fall", 32'(oSPI_CSN), 32'd0);
    chk("end_low_at_start", 32'(oSPI_END), 32'd0);
    if (exp_gap > 0) chk("csn_high_cycles", 32'(csn_high), 32'(exp_gap));

    n = 0;
    while (oSPI_END !== 1'b1 && n < 40) begin
      @(negedge iSPI_CLK);
      if (n == drop_at) iSPI_GO = 1'b0;
      @(posedge iSPI_CLK); #1;
      n++;
      if (word[15] && n == 7) chk("sdio_drv_e7", 32'(SPI_SDIO), 32'(word[8]));
      if (word[15] && n == 8) chk("sdio_rel_e8", 32'(SPI_SDIO), 32'd1);
    end
    chk("end_latency", 32'(n), 32'd16);
    chk("csn_after_end", 32'(oSPI_CSN), 32'd1);
    chk("sclk_pulses", 32'(rise_cnt), 32'd16);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("bus_bits", 32'(cap), 32'(e.bus));
      chk("s2p", 32'(oS2P_DATA), 32'(e.s2p));
    end else begin
      chk("sb_nonempty", 32'(sb.size()), 32'd1);
    end

    for (int i = 0; i < hold; i++) begin
      @(posedge iSPI_CLK); #1;
      chk("end_hold", 32'(oSPI_END), 32'd1);
      chk("no_restart_csn", 32'(oSPI_CSN), 32'd1);
    end
    if (iSPI_GO) begin
      @(negedge iSPI_CLK);
      iSPI_GO = 1'b0;
    end
    @(posedge iSPI_CLK); #1;
    chk("end_clear", 32'(oSPI_END), 32'd0);
  endtask

  logic [15:0] wr_tab [11] = '{16'h3108, 16'h2C0A, 16'h2D08, 16'h1E7F, 16'h1F81,
                               16'h2000, 16'h2E80, 16'h2F00, 16'h38FF, 16'h1D55, 16'h2AAA};

  initial begin
    int n;

    // reset state, sampled while iSPI_CLK_OUT is low
    repeat (3) @(posedge iSPI_CLK);
    @(negedge iSPI_CLK);
    chk("rst_csn", 32'(oSPI_CSN), 32'd1);
    chk("rst_sclk", 32'(oSPI_CLK), 32'd1);
    chk("rst_sdio", 32'(SPI_SDIO), 32'd1);
    chk("rst_end", 32'(oSPI_END), 32'd0);
    chk("rst_s2p", 32'(oS2P_DATA), 32'd0);
    iRSTN = 1'b1;

    // write with END held while GO stays high (no second frame)
    do_frame(16'h2D08, 8'h00, -1, 3, 0);
    do_frame(16'hB000, 8'hA5, -1, 0, 0);
    for (int i = 0; i < 11; i++) do_frame(wr_tab[i], 8'h00, -1, 0, GAP_EXP);
    // GO dropped mid-frame: frame completes, END pulses one cycle
    do_frame(16'h2C0A, 8'h00, 5, 0, GAP_EXP);
    do_frame(16'hF200, 8'h3C, -1, 0, GAP_EXP);
    do_frame(16'h2D00, 8'h00, -1, 0, GAP_EXP);

    // async reset in slot 10 of a read
    slv_rd = 1'b1;
    slv_byte = 8'h5A;
    @(negedge iSPI_CLK);
    iP2S_DATA = 16'hB100;
    iSPI_GO = 1'b1;
    n = 0;
    do begin
      @(posedge iSPI_CLK); #1;
      n++;
    end while (oSPI_CSN !== 1'b0 && n < 20);
    chk("rd_abort_csn_fall", 32'(oSPI_CSN), 32'd0);
    n = 0;
    while (n < 10) begin
      @(posedge iSPI_CLK); #1;
      n++;
    end
    @(negedge iSPI_CLK);
    chk("sclk_low_pre_rst", 32'(oSPI_CLK), 32'd0);
    iRSTN = 1'b0;
    #1;
    chk("mid_rst_csn", 32'(oSPI_CSN), 32'd1);
    chk("mid_rst_sclk", 32'(oSPI_CLK), 32'd1);
    chk("mid_rst_sdio", 32'(SPI_SDIO), 32'd1);
    chk("mid_rst_end", 32'(oSPI_END), 32'd0);
    chk("mid_rst_s2p", 32'(oS2P_DATA), 32'd0);
    m_s2p = 8'h00;
    iSPI_GO = 1'b0;
    @(negedge iSPI_CLK);
    iRSTN = 1'b1;

    // clean frames after reset
    do_frame(16'hB000, 8'hC3, -1, 0, 0);
    do_frame(16'h2D08, 8'h00, -1, 0, GAP_EXP);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
